// File: rtl/ov7670_reg_sequencer.sv
// OV7670 register-configuration sequencer.
// Walks a register table held in an external synchronous ROM and turns each
// entry into one SCCB write. Entry 16'hFFFF ends the table; 16'hFFF0 inserts
// a DELAY_MS wait. A table with no end marker stops after its last entry.
// Optional feature macro: OV7670_SOFT_RESET_EN -- when defined, every pass
// first writes COM7 = 0x80 (soft reset) and waits one delay period before
// fetching entry 0.
module ov7670_reg_sequencer #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned DELAY_MS = 10,
  parameter int unsigned ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic [7:0]        sccb_address,
  output logic [7:0]        sccb_data,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic [ROM_AW:0]   reg_count
);

  localparam int unsigned DelayCycles = CLK_FREQ / 1000 * DELAY_MS;
  // Keep the timer at least one bit wide for degenerate 1-cycle delays.
  localparam int unsigned TimerW = (DelayCycles > 1) ? $clog2(DelayCycles) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(DelayCycles - 1);
  localparam logic [ROM_AW:0]   CountMax  = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [ROM_AW-1:0] AddrLast  = {ROM_AW{1'b1}};
  localparam logic [15:0]       MarkEnd   = 16'hFFFF;
  localparam logic [15:0]       MarkDelay = 16'hFFF0;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitAccept,
    StWaitDone,
    StDelay,
    StNext,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   addr_q, addr_d;
  logic [7:0]          reg_addr_q, reg_addr_d;
  logic [7:0]          reg_data_q, reg_data_d;
  logic [ROM_AW:0]     count_q, count_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                done_q, done_d;
`ifdef OV7670_SOFT_RESET_EN
  // Set while the built-in COM7 soft-reset write and its delay are in progress.
  logic                soft_q, soft_d;
`endif

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
`ifdef OV7670_SOFT_RESET_EN
      soft_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
`ifdef OV7670_SOFT_RESET_EN
      soft_q     <= soft_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    count_d    = count_q;
    timer_d    = timer_q;
    done_d     = done_q;
`ifdef OV7670_SOFT_RESET_EN
    soft_d     = soft_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        // cfg_start is only honoured here; it is ignored mid-pass.
        if (cfg_start) begin
          addr_d  = '0;
          count_d = '0;
          done_d  = 1'b0;
`ifdef OV7670_SOFT_RESET_EN
          reg_addr_d = 8'h12;
          reg_data_d = 8'h80;
          soft_d     = 1'b1;
          state_d    = StIssue;
`else
          state_d    = StFetch;
`endif
        end
      end

      // One cycle of ROM read latency.
      StFetch: state_d = StDecode;

      StDecode: begin
        if (rom_data == MarkEnd) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (rom_data == MarkDelay) begin
          timer_d = TimerLoad;
          state_d = StDelay;
        end else begin
          reg_addr_d = rom_data[15:8];
          reg_data_d = rom_data[7:0];
          state_d    = StIssue;
        end
      end

      // Never raise a request while the SCCB side is still busy.
      StIssue: if (sccb_ready) state_d = StWaitAccept;

      // Request held until the SCCB side drops ready to show it took it.
      StWaitAccept: if (!sccb_ready) state_d = StWaitDone;

      StWaitDone: begin
        if (sccb_ready) begin
          if (count_q != CountMax) count_d = count_q + 1'b1;
          state_d = StNext;
`ifdef OV7670_SOFT_RESET_EN
          if (soft_q) begin
            timer_d = TimerLoad;
            state_d = StDelay;
          end
`endif
        end
      end

      StDelay: begin
        if (timer_q == '0) begin
          state_d = StNext;
`ifdef OV7670_SOFT_RESET_EN
          // After the soft-reset delay, start the table at entry 0.
          if (soft_q) begin
            soft_d  = 1'b0;
            state_d = StFetch;
          end
`endif
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StNext: begin
        if (addr_q == AddrLast) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StFetch;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign rom_addr     = addr_q;
  assign sccb_start   = (state_q == StWaitAccept);
  assign sccb_address = reg_addr_q;
  assign sccb_data    = reg_data_q;
  assign cfg_busy     = (state_q != StIdle) && (state_q != StDone);
  assign cfg_done     = done_q;
  assign reg_count    = count_q;

endmodule
